// File: rtl/lab8_pkg.sv
// Shared definitions for the lab8 Gray-code state register and its arbiter:
// state encodings, arbiter FSM encoding and the SET/CLR command selector.
package lab8_pkg;

    // lab8 state encoding (Gray sequence S0 -> S1 -> S2 -> S3 -> S0)
    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b11;
    localparam logic [1:0] S3 = 2'b10;

    // Arbiter FSM encoding
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Last GRANT cycle index (cyc counts commands already issued)
    localparam logic [1:0] GRANT_CYC_LAST = 2'd2;

    // Saturation value of the per-requester grant counters
    localparam logic [7:0] GNT_CNT_MAX = 8'd255;

    // Command to steer lab8 from 'state' towards 'tgt', returned as {set, clr}.
    // S0 and S2 are reachable directly by CLR/SET. S1 and S3 are reached by
    // letting lab8 free-run from the state just before them; when lab8 is not
    // already there, jump to that predecessor (S0 via CLR, S2 via SET).
    function automatic logic [1:0] next_cmd(input logic [1:0] state,
                                            input logic [1:0] tgt);
        logic [1:0] cmd;
        cmd = 2'b00;
        case (tgt)
            S0:      cmd = 2'b01;
            S2:      cmd = 2'b10;
            S1:      cmd = (state == S0) ? 2'b00 : 2'b01;
            default: cmd = (state == S2) ? 2'b00 : 2'b10;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lab8_rr2.sv
// Two-way round-robin picker. A lone request always wins; on a tie the
// requester that did not win last time is chosen. 'last' resets to 1 so
// requester 0 takes the first tie after reset.
module lab8_rr2
    import lab8_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic winner
);

    logic last_reg;

    // Winner selection from the current requests and the previous winner
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_reg;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    // Remember the winner whenever a grant is actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= winner;
        end
    end

endmodule

// File: rtl/lab8_arb.sv
// Two-requester arbiter/sequencer sharing one lab8 Gray-code register.
// A granted requester's target state is reached by driving lab8 SET/CLR for
// at most two cycles; ack (or err after three GRANT cycles) is combinational
// from the registered grant plus the observed lab8 state.
// Optional build macro: LAB8_ARB_STATS_EN enables the saturating per-requester
// grant counters; without it gnt_cnt0/gnt_cnt1 read constant zero.
module lab8_arb
    import lab8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] tgt0,
    output logic       ack0,
    input  logic       req1,
    input  logic [1:0] tgt1,
    output logic       ack1,
    input  logic [1:0] fsm_state,
    output logic       fsm_set,
    output logic       fsm_clr,
    output logic       busy,
    output logic       grant_id,
    output logic       err,
    output logic [7:0] gnt_cnt0,
    output logic [7:0] gnt_cnt1
);

    arb_state_t state_reg, state_next;
    logic [1:0] tgt_reg,   tgt_next;
    logic       gid_reg,   gid_next;
    logic [1:0] cyc_reg,   cyc_next;

    logic       any_req;
    logic       start;
    logic       winner;
    logic [1:0] cmd;

    assign any_req = req0 | req1;

    // A grant is taken on any IDLE cycle that sees a request
    assign start = (state_reg == IDLE) && any_req;

    // Command towards the latched target given the state lab8 shows right now
    assign cmd = next_cmd(fsm_state, tgt_reg);

    lab8_rr2 u_rr2 (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .advance (start),
        .winner  (winner)
    );

    // Registered arbiter state; reset returns to IDLE immediately so the
    // combinational SET/CLR/ack/err outputs drop with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            tgt_reg   <= S0;
            gid_reg   <= 1'b0;
            cyc_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            gid_reg   <= gid_next;
            cyc_reg   <= cyc_next;
        end
    end

    // Next-state and output decode: arbitration in IDLE, sequencing in GRANT
    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        gid_next   = gid_reg;
        cyc_next   = cyc_reg;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err        = 1'b0;
        fsm_set    = 1'b0;
        fsm_clr    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = GRANT;
                    gid_next   = winner;
                    tgt_next   = winner ? tgt1 : tgt0;
                    cyc_next   = 2'd0;
                end
            end
            GRANT: begin
                if (fsm_state == tgt_reg) begin
                    // Target visible this cycle: acknowledge the owner
                    ack0       = ~gid_reg;
                    ack1       = gid_reg;
                    state_next = IDLE;
                end else if (cyc_reg == GRANT_CYC_LAST) begin
                    // Two commands issued and still not there: give up
                    err        = 1'b1;
                    state_next = IDLE;
                end else begin
                    fsm_set    = cmd[1];
                    fsm_clr    = cmd[0];
                    cyc_next   = cyc_reg + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg == GRANT);
    assign grant_id = gid_reg;

`ifdef LAB8_ARB_STATS_EN
    // One-hot "grant taken this edge" per requester
    logic [1:0] grant_hot;
    assign grant_hot = {start & winner, start & ~winner};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [7:0] cnt_reg;

            // Saturating count of grants handed to requester gi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= 8'd0;
                end else if (grant_hot[gi] && (cnt_reg != GNT_CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end
        end
    endgenerate

    assign gnt_cnt0 = g_cnt[0].cnt_reg;
    assign gnt_cnt1 = g_cnt[1].cnt_reg;
`else
    assign gnt_cnt0 = 8'd0;
    assign gnt_cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_lab8_arb.sv
// Testbench for lab8_arb with a behavioural lab8 register fed back on
// fsm_state. A reference model predicts each grant's outcome when it is
// issued and queues it; a negedge monitor compares DUT responses against it.
`timescale 1ns/1ps
module tb_lab8_arb;
    import lab8_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [1:0] tgt0 = 2'b00;
    logic [1:0] tgt1 = 2'b00;
    logic       ack0, ack1, fsm_set, fsm_clr, busy, grant_id, err;
    logic [7:0] gnt_cnt0, gnt_cnt1;
    logic [1:0] fsm_state;

    logic [1:0] lab8_q;
    logic       force_en = 1'b0;
    logic [1:0] force_val = 2'b10;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         cyc;   // cycle number in which the response must appear
        int         kind;  // 0 ack0, 1 ack1, 2 err
        logic [1:0] st;    // fsm_state seen in that cycle
        logic       gid;
    } exp_t;

    exp_t exp_q[$];

    int   cyc_count   = 0;
    int   m_free_at   = 0;
    int   m_busy_from = 1;
    int   m_busy_to   = 0;
    int   m_cnt0      = 0;
    int   m_cnt1      = 0;
    logic m_last      = 1'b1;

    always #5 clk = ~clk;

    assign fsm_state = force_en ? force_val : lab8_q;

    lab8_arb dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .tgt0      (tgt0),
        .ack0      (ack0),
        .req1      (req1),
        .tgt1      (tgt1),
        .ack1      (ack1),
        .fsm_state (fsm_state),
        .fsm_set   (fsm_set),
        .fsm_clr   (fsm_clr),
        .busy      (busy),
        .grant_id  (grant_id),
        .err       (err),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    // lab8 behaviour: CLR -> S0, SET -> S2, otherwise step along the sequence
    function automatic logic [1:0] l8_step(input logic [1:0] s, input logic set, input logic clr);
        if (clr) return S0;
        if (set) return S2;
        case (s)
            S0:      return S1;
            S1:      return S2;
            S2:      return S3;
            default: return S0;
        endcase
    endfunction

    // Reference steering: jump straight to S0/S2, otherwise free-run if that
    // lands on the target, otherwise jump to whichever state precedes it.
    function automatic logic [1:0] ref_cmd(input logic [1:0] s, input logic [1:0] t);
        logic [1:0] p;
        if (t == S0) return 2'b01;
        if (t == S2) return 2'b10;
        if (l8_step(s, 1'b0, 1'b0) == t) return 2'b00;
        p = S0;
        for (int i = 0; i < 4; i++) begin
            if (l8_step(2'(i), 1'b0, 1'b0) == t) p = 2'(i);
        end
        return (p == S0) ? 2'b01 : 2'b10;
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef LAB8_ARB_STATS_EN
        return (c > 255) ? 255 : c;
`else
        return (c >= 0) ? 0 : 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_count);
    endtask

    // lab8 register model
    always @(posedge clk) begin : lab8_model
        if (reset) lab8_q <= S0;
        else       lab8_q <= l8_step(lab8_q, fsm_set, fsm_clr);
    end

    // Reference model: decide grants and predict their whole outcome up front
    always @(posedge clk) begin : ref_model
        int         n;
        int         c;
        logic       w;
        logic [1:0] s;
        logic [1:0] t;
        logic [1:0] cm;
        bit         done;
        exp_t       e;
        cyc_count <= cyc_count + 1;
        if (reset) begin
            exp_q.delete();
            m_last      <= 1'b1;
            m_free_at   <= 0;
            m_busy_from <= 1;
            m_busy_to   <= 0;
            m_cnt0      <= 0;
            m_cnt1      <= 0;
        end else begin
            n = cyc_count + 1;
            if ((n >= m_free_at) && (req0 || req1)) begin
                w = (req0 && req1) ? ~m_last : req1;
                t = w ? tgt1 : tgt0;
                s = force_en ? force_val : l8_step(lab8_q, 1'b0, 1'b0);
                c = 0;
                done = 1'b0;
                e.kind = 2;
                for (int k = 1; k <= 3 && !done; k++) begin
                    if (s == t) begin
                        e.kind = w ? 1 : 0; c = k; done = 1'b1;
                    end else if (k == 3) begin
                        e.kind = 2; c = 3; done = 1'b1;
                    end else begin
                        cm = ref_cmd(s, t);
                        if (!force_en) s = l8_step(s, cm[1], cm[0]);
                    end
                end
                e.cyc = n + c - 1;
                e.st  = s;
                e.gid = w;
                exp_q.push_back(e);
                m_free_at   <= n + c + 1;
                m_busy_from <= n;
                m_busy_to   <= n + c - 1;
                m_last      <= w;
                if (w) m_cnt1 <= m_cnt1 + 1;
                else   m_cnt0 <= m_cnt0 + 1;
            end
        end
    end

    // Monitor: per-cycle protocol checks and scoreboard pops on ack/err
    always @(negedge clk) begin : monitor
        exp_t e;
        int   kind;
        bit   exp_busy;
        if (!reset) begin
            exp_busy = (cyc_count >= m_busy_from) && (cyc_count <= m_busy_to);
            check("busy", int'(busy), int'(exp_busy));
            check("set_clr_excl", int'(fsm_set & fsm_clr), 0);
            if (!exp_busy) check("idle_no_cmd", int'({fsm_set, fsm_clr}), 0);
            if (ack0 || ack1 || err) begin
                check("one_resp", int'(ack0) + int'(ack1) + int'(err), 1);
                kind = ack0 ? 0 : (ack1 ? 1 : 2);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: got kind %0d expected none (cycle %0d)", kind, cyc_count);
                end else begin
                    e = exp_q.pop_front();
                    $display("resp cycle=%0d gid=%0d kind=%0d state=%b", cyc_count, grant_id, kind, fsm_state);
                    check("resp_cycle", cyc_count, e.cyc);
                    check("resp_kind", kind, e.kind);
                    check("resp_state", int'(fsm_state), int'(e.st));
                    check("resp_gid", int'(grant_id), int'(e.gid));
                end
            end else if ((exp_q.size() != 0) && (cyc_count >= exp_q[0].cyc)) begin
                e = exp_q.pop_front();
                n_checks++;
                $display("FAIL missing_resp: got nothing expected kind %0d at cycle %0d", e.kind, e.cyc);
            end
        end
    end

    // Requester behaviour: release on own ack/err, raise new requests randomly
    task automatic step_reqs(input int p0, input int p1);
        if (req0 && (ack0 || (err && grant_id == 1'b0))) req0 = 1'b0;
        if (req1 && (ack1 || (err && grant_id == 1'b1))) req1 = 1'b0;
        if (!req0 && ($urandom_range(0, 99) < p0)) begin
            req0 = 1'b1;
            tgt0 = 2'($urandom_range(0, 3));
        end
        if (!req1 && ($urandom_range(0, 99) < p1)) begin
            req1 = 1'b1;
            tgt1 = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while ((req0 || req1 || exp_q.size() != 0) && k < limit) begin
            @(negedge clk);
            step_reqs(0, 0);
            k++;
        end
        if (k >= limit) begin
            n_checks++;
            $display("FAIL wait_done: requests still pending after %0d cycles, expected drained", limit);
            req0 = 1'b0;
            req1 = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_lab8(input logic [1:0] v);
        int k;
        k = 0;
        @(negedge clk);
        while (lab8_q != v && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10) begin
            n_checks++;
            $display("FAIL wait_lab8: lab8 state %b never reached %b", lab8_q, v);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_ack0", int'(ack0), 0);
        check("rst_ack1", int'(ack1), 0);
        check("rst_err", int'(err), 0);
        check("rst_set", int'(fsm_set), 0);
        check("rst_clr", int'(fsm_clr), 0);
        check("rst_gid", int'(grant_id), 0);
        check("rst_cnt0", int'(gnt_cnt0), 0);
        check("rst_cnt1", int'(gnt_cnt1), 0);

        // Tie on the first grant after reset: requester 0 first, then 1
        req0 = 1'b1; tgt0 = S3;
        req1 = 1'b1; tgt1 = S0;
        #1 reset = 1'b0;
        wait_done(40);

        // Grant seeing S0 with target S1
        wait_lab8(S3);
        req0 = 1'b1; tgt0 = S1;
        wait_done(20);

        // Grant seeing S3 with target S1: clr, none, ack in cycle 3
        wait_lab8(S2);
        req0 = 1'b1; tgt0 = S1;
        wait_done(20);

        // State held at S3 by override: err in cycle 3
        force_val = S3;
        force_en  = 1'b1;
        req1 = 1'b1; tgt1 = S1;
        wait_done(20);
        force_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during GRANT cycle 2 while a command is being driven
        force_val = S3;
        force_en  = 1'b1;
        req0 = 1'b1; tgt0 = S1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_clr", int'(fsm_clr), 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_set", int'(fsm_set), 0);
        check("midrst_clr", int'(fsm_clr), 0);
        check("midrst_ack0", int'(ack0), 0);
        check("midrst_ack1", int'(ack1), 0);
        check("midrst_err", int'(err), 0);
        @(negedge clk);
        force_en = 1'b0;
        req1 = 1'b1; tgt1 = S2;
        #1 reset = 1'b0;
        wait_done(40);

        // Random traffic on both channels
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            step_reqs(30, 30);
        end
        wait_done(50);
        check("mid_cnt0", int'(gnt_cnt0), exp_cnt(m_cnt0));
        check("mid_cnt1", int'(gnt_cnt1), exp_cnt(m_cnt1));

        // Counter saturation: reset, then 300 grants to requester 1 only
        reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        k = 0;
        while (m_cnt1 < 300 && k < 3000) begin
            @(negedge clk);
            step_reqs(0, 100);
            k++;
        end
        if (k >= 3000) begin
            n_checks++;
            $display("FAIL sat_loop: only %0d grants to requester 1, expected 300", m_cnt1);
        end
        wait_done(20);
        check("sat_cnt0", int'(gnt_cnt0), exp_cnt(m_cnt0));
        check("sat_cnt1", int'(gnt_cnt1), exp_cnt(m_cnt1));
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lab8_arb.md
# lab8_arb

Two-requester arbiter and sequencer for the `lab8` Gray-code state register. It shares one `lab8` instance between two client channels, each of which asks for a target state. It drives `lab8`'s SET/CLR inputs cycle by cycle until the observed state equals the target, then acknowledges. It sits beside `lab8` on the same clock and is the only block allowed to drive `lab8`'s SET/CLR.

## Interface
- No parameters. State encoding comes from the shared package: S0=2'b00, S1=2'b01, S2=2'b11, S3=2'b10.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request; held high until ack0 or err with grant_id=0.
- tgt0  in  [0:1]  requester 0 target state; stable while req0 is high.
- ack0  out  1  one-cycle pulse; `lab8` state equals tgt0 in this cycle.
- req1, tgt1, ack1  same as channel 0, for requester 1.
- fsm_state  in  [0:1]  current `lab8` state output.
- fsm_set  out  1  drives `lab8` SET.
- fsm_clr  out  1  drives `lab8` CLR.
- busy  out  1  high in GRANT.
- grant_id  out  1  requester currently or last granted.
- err  out  1  one-cycle pulse when the target is not reached in 3 GRANT cycles.
- gnt_cnt0, gnt_cnt1  out  8  grant counters; see Configuration.

## Operation
- `lab8` behaviour being controlled, applied at each edge:
  - CLR=1 → S0.
  - SET=1 → S2.
  - Neither → advance S0→S1→S2→S3→S0.
  - `lab8` cannot hold a state, so a target is only guaranteed valid in the cycle it is acknowledged.
- FSM has two states, IDLE and GRANT. Internal registers: tgt_q, gid_q, cyc (2 bits), last (1 bit).
- IDLE:
  - If any req is high, pick a winner and go to GRANT next edge. Latch tgt_q and gid_q; cyc=0.
  - Only one request high → grant it.
  - Both high → grant !last (round robin).
  - On grant, last ← winner.
- GRANT, each cycle, evaluated combinationally from fsm_state and tgt_q:
  - fsm_state==tgt_q → ack[gid_q]=1, set=clr=0, next IDLE.
  - Otherwise, if cyc==2 → err=1, set=clr=0, next IDLE, no ack.
  - Otherwise drive the command below, cyc++.
- Command rule:
  - tgt S0 → clr.
  - tgt S2 → set.
  - tgt S1 → none if state==S0, else clr.
  - tgt S3 → none if state==S2, else set.
- fsm_set and fsm_clr are never both 1. Both are 0 outside GRANT, so `lab8` free-runs when idle.
- Dropping req while in GRANT does not abort the grant; the ack still fires and the requester ignores it.
- Requester still holding req after its ack is a fresh request, re-arbitrated in the next IDLE cycle.

## Timing
- Reset values:
  - Outputs: ack0/1, err, busy, fsm_set, fsm_clr, grant_id, gnt_cnt* all 0.
  - Internal: state IDLE, last=1 (so req0 wins the first tie), cyc=0.
- Reset asserted mid-GRANT: immediate return to IDLE, no ack, no err, set/clr drop asynchronously.
- Request latency: req sampled at edge N, busy high from N+1.
- Ack timing: ack in GRANT cycle 1, 2 or 3 (0, 1 or 2 commands issued). err only in GRANT cycle 3.
- IDLE lasts at least one cycle between grants.
- Throughput: at most one grant per 2 cycles.
- ack and err are combinational from registered state plus fsm_state. They are valid before the rising edge of the cycle they are asserted in.

## Configuration
- LAB8_ARB_STATS_EN
  - Defined: gnt_cnt0/gnt_cnt1 count grants to each requester. Each increments on entry to GRANT, saturates at 255, and resets to 0.
  - Undefined: counter registers are not built and both ports are tied to 8'd0. Ports stay present in both builds.

## Structure
- Package `lab8_pkg` holds:
  - State localparams S0..S3.
  - Arbiter FSM encoding IDLE/GRANT.
  - Function `next_cmd(state, tgt)` returning {set, clr}.
- Sub-module `lab8_rr2`: 2-way round-robin pick with a `last` register. Inputs req0, req1, advance; output winner.
- Top-level bench instantiates `lab8_arb` plus a real `lab8`, with fsm_state fed back.

## Test plan
- Reset, then `lab8` in S0, req0=1, tgt0=S1 → busy next cycle; ack0 in GRANT cycle 1, 2 or 3 with fsm_state==01 in that cycle; fsm_set=fsm_clr=1 never seen.
- Both req high, tgt0=S3, tgt1=S0, first grant after reset → grant_id=0 first, ack0 with state 10. Then grant_id=1, ack1 with state 00.
- `lab8` at S3, tgt=S1 → fsm_clr=1, then none, then ack on GRANT cycle 3.
- Force fsm_state=S3 by a bench override, tgt=S1 → err pulse in GRANT cycle 3, no ack, return to IDLE.
- reset pulsed during GRANT cycle 2 → busy, fsm_set, fsm_clr, ack and err are all 0 immediately; next grant goes to req0.
- With LAB8_ARB_STATS_EN defined, 300 grants to requester 1 → gnt_cnt1=255, gnt_cnt0=0. Undefined → both read 0.
